// File: rtl/lsq_pkg.sv
// Shared LSQ request definitions: opcode encoding and opcode classification.
package lsq_pkg;

   typedef logic [3:0] lsq_op_t;

   localparam lsq_op_t OP_LOAD  = 4'h0;
   localparam lsq_op_t OP_STORE = 4'h1;

   function automatic logic is_mem_op(input lsq_op_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/lsq_tag_fifo.sv
// Synchronous FIFO of requester indices for outstanding loads, oldest at head.
module lsq_tag_fifo #(
   parameter int TAG_W = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [TAG_W-1:0]         din,
   output logic [TAG_W-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle does not make room for a push when full.
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/lsq_req_arbiter.sv
// Round-robin arbiter sharing one LSQ request port among NREQ requesters, with load
// response routing. Define LSQ_ARB_PRIO_EN to give requester 0 absolute priority.
module lsq_req_arbiter
   import lsq_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NREQ   = 4,
   parameter int MAXOUT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*4-1:0]     req_opcode,
   input  logic [NREQ*WIDTH-1:0] req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  lsq_req_valid,
   output logic [3:0]            lsq_opcode,
   output logic [WIDTH-1:0]      lsq_addr,
   output logic [WIDTH-1:0]      lsq_data_in,
   input  logic                  lsq_store_full,
   input  logic                  lsq_load_full,
   input  logic                  lsq_load_valid,
   input  logic [WIDTH-1:0]      lsq_data_out,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  err
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(MAXOUT) + 1;
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

   lsq_op_t          req_op [NREQ];
   logic [NREQ-1:0]  elig;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_next;
   logic             ptr_upd;
   logic [IDX_W-1:0] winner;
   logic             grant;
   lsq_op_t          win_op;
   logic             push;
   logic             pop;
   logic             orphan;
   logic             bad_op;
   logic [IDX_W-1:0] tag_head;
   logic [CNT_W-1:0] tag_count;
   logic             tag_empty;
   logic [NREQ-1:0]  rsp_valid_p1;
   logic [WIDTH-1:0] rsp_data_p1;
   logic             err_p1;

   for (genvar i = 0; i < NREQ; i++) begin : g_op
      assign req_op[i] = lsq_op_t'(req_opcode[i*4 +: 4]);
   end

   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         unique case (req_op[i])
            OP_STORE: elig[i] = req_valid[i] && !lsq_store_full;
            OP_LOAD:  elig[i] = req_valid[i] && !lsq_load_full && (tag_count < CNT_W'(MAXOUT));
            default:  elig[i] = req_valid[i];
         endcase
         if (rst) elig[i] = 1'b0;
      end
   end

`ifdef LSQ_ARB_PRIO_EN
   int rr_base;

   // Requester 0 preempts; the rotating pointer only ever covers 1..NREQ-1.
   always_comb begin
      grant   = 1'b0;
      winner  = '0;
      rr_base = (ptr == '0) ? 0 : int'(ptr) - 1;
      if (elig[0]) begin
         grant = 1'b1;
      end else begin
         for (int k = 0; k < NREQ - 1; k++) begin
            if (!grant && elig[1 + ((rr_base + k) % (NREQ - 1))]) begin
               grant  = 1'b1;
               winner = IDX_W'(1 + ((rr_base + k) % (NREQ - 1)));
            end
         end
      end
      ptr_upd  = grant && (winner != '0);
      ptr_next = (winner == IDX_LAST) ? IDX_ONE : winner + IDX_ONE;
   end
`else
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant && elig[(int'(ptr) + k) % NREQ]) begin
            grant  = 1'b1;
            winner = IDX_W'((int'(ptr) + k) % NREQ);
         end
      end
      ptr_upd  = grant;
      ptr_next = (winner == IDX_LAST) ? '0 : winner + IDX_ONE;
   end
`endif

   always_comb begin
      req_ready     = '0;
      lsq_req_valid = 1'b0;
      lsq_opcode    = '0;
      lsq_addr      = '0;
      lsq_data_in   = '0;
      win_op        = OP_LOAD;
      if (grant) begin
         win_op            = req_op[winner];
         req_ready[winner] = 1'b1;
         lsq_req_valid     = is_mem_op(win_op);
         lsq_opcode        = win_op;
         lsq_addr          = req_addr[winner*WIDTH +: WIDTH];
         lsq_data_in       = req_data[winner*WIDTH +: WIDTH];
      end
   end

   assign push   = grant && (win_op == OP_LOAD);
   assign pop    = lsq_load_valid && !tag_empty;
   assign orphan = lsq_load_valid && tag_empty;
   assign bad_op = grant && !is_mem_op(win_op);

   lsq_tag_fifo #(
      .TAG_W (IDX_W),
      .DEPTH (MAXOUT)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (winner),
      .head  (tag_head),
      .count (tag_count),
      .empty (tag_empty)
   );

   // stage p1: routed load response, error pulse and pointer advance
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         rsp_valid_p1 <= '0;
         rsp_data_p1  <= '0;
         err_p1       <= 1'b0;
      end else begin
         if (ptr_upd) ptr <= ptr_next;
         rsp_valid_p1 <= pop ? (NREQ'(1) << tag_head) : '0;
         if (pop) rsp_data_p1 <= lsq_data_out;
         err_p1 <= bad_op || orphan;
      end
   end

   assign rsp_valid = rsp_valid_p1;
   assign rsp_data  = rsp_data_p1;
   assign err       = err_p1;

endmodule

// File: tb/tb_lsq_req_arbiter.sv
// Randomized and directed bench for lsq_req_arbiter against a queue-based reference model.
module tb_lsq_req_arbiter;
   import lsq_pkg::*;

   localparam int WIDTH  = 32;
   localparam int NREQ   = 4;
   localparam int MAXOUT = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*4-1:0]     req_opcode;
   logic [NREQ*WIDTH-1:0] req_addr;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  lsq_req_valid;
   logic [3:0]            lsq_opcode;
   logic [WIDTH-1:0]      lsq_addr;
   logic [WIDTH-1:0]      lsq_data_in;
   logic                  lsq_store_full;
   logic                  lsq_load_full;
   logic                  lsq_load_valid;
   logic [WIDTH-1:0]      lsq_data_out;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  err;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int               m_ptr = 0;
   int               m_q[$];
   logic [NREQ-1:0]  e_rv  = '0;
   logic [WIDTH-1:0] e_rd  = '0;
   logic             e_err = 1'b0;

   always #5 clk = ~clk;

   lsq_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAXOUT(MAXOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_opcode     (req_opcode),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .lsq_req_valid  (lsq_req_valid),
      .lsq_opcode     (lsq_opcode),
      .lsq_addr       (lsq_addr),
      .lsq_data_in    (lsq_data_in),
      .lsq_store_full (lsq_store_full),
      .lsq_load_full  (lsq_load_full),
      .lsq_load_valid (lsq_load_valid),
      .lsq_data_out   (lsq_data_out),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .err            (err)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic idle();
      req_valid      = '0;
      req_opcode     = '0;
      req_addr       = '0;
      req_data       = '0;
      lsq_store_full = 1'b0;
      lsq_load_full  = 1'b0;
      lsq_load_valid = 1'b0;
      lsq_data_out   = '0;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] d);
      req_valid[i]              = 1'b1;
      req_opcode[i*4 +: 4]      = op;
      req_addr[i*WIDTH +: WIDTH] = a;
      req_data[i*WIDTH +: WIDTH] = d;
   endtask

   function automatic bit m_elig(input int i);
      logic [3:0] op;
      op = req_opcode[i*4 +: 4];
      if (!req_valid[i]) return 1'b0;
      if (op == OP_STORE) return !lsq_store_full;
      if (op == OP_LOAD) return !lsq_load_full && (m_q.size() < MAXOUT);
      return 1'b1;
   endfunction

   function automatic int m_winner();
      int start;
      if (rst) return -1;
`ifdef LSQ_ARB_PRIO_EN
      if (m_elig(0)) return 0;
      start = (m_ptr == 0) ? 1 : m_ptr;
      for (int k = 0; k < NREQ - 1; k++) begin
         if (m_elig(1 + ((start - 1 + k) % (NREQ - 1)))) return 1 + ((start - 1 + k) % (NREQ - 1));
      end
`else
      start = m_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (m_elig((start + k) % NREQ)) return (start + k) % NREQ;
      end
`endif
      return -1;
   endfunction

   // One clock: check the combinational grant, advance the model, check registered outputs.
   task automatic step();
      int               w;
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] d;
      logic [63:0]      x_ready;
      logic             lv;
      logic             r;
      logic [WIDTH-1:0] dout;
      #1;
      w = m_winner();
      op = 4'h0; a = '0; d = '0; x_ready = '0;
      if (w >= 0) begin
         op = req_opcode[w*4 +: 4];
         a  = req_addr[w*WIDTH +: WIDTH];
         d  = req_data[w*WIDTH +: WIDTH];
         x_ready = 64'(1) << w;
      end
      chk("req_ready", 64'(req_ready), x_ready);
      chk("lsq_req_valid", 64'(lsq_req_valid), 64'((w >= 0) && (op <= 4'h1)));
      chk("lsq_opcode", 64'(lsq_opcode), 64'(op));
      chk("lsq_addr", 64'(lsq_addr), 64'(a));
      chk("lsq_data_in", 64'(lsq_data_in), 64'(d));
      lv = lsq_load_valid; dout = lsq_data_out; r = rst;
      @(posedge clk);
      #1;
      if (r) begin
         m_ptr = 0; m_q.delete(); e_rv = '0; e_rd = '0; e_err = 1'b0;
      end else begin
         e_err = ((w >= 0) && (op > 4'h1)) || (lv && (m_q.size() == 0));
         e_rv  = '0;
         if (lv && (m_q.size() > 0)) begin
            e_rv[m_q[0]] = 1'b1;
            e_rd = dout;
            void'(m_q.pop_front());
         end
         if ((w >= 0) && (op == OP_LOAD)) m_q.push_back(w);
`ifdef LSQ_ARB_PRIO_EN
         if (w > 0) m_ptr = (w + 1 == NREQ) ? 1 : w + 1;
`else
         if (w >= 0) m_ptr = (w + 1) % NREQ;
`endif
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("err", 64'(err), 64'(e_err));
      if (e_rv != '0) chk("rsp_data", 64'(rsp_data), 64'(e_rd));
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      do_reset();
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      chk("reset_err", 64'(err), 64'(0));

      // single store
      set_req(1, OP_STORE, 32'h100, 32'hDEADBEEF);
      #1;
      chk("t1_ready", 64'(req_ready), 64'(4'b0010));
      chk("t1_valid", 64'(lsq_req_valid), 64'(1));
      chk("t1_addr", 64'(lsq_addr), 64'(32'h100));
      chk("t1_data", 64'(lsq_data_in), 64'(32'hDEADBEEF));
      step();
      idle();

`ifdef LSQ_ARB_PRIO_EN
      do_reset();
      set_req(0, OP_STORE, 32'h10, 32'h1);
      set_req(1, OP_STORE, 32'h20, 32'h2);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("prio_grant", 64'(req_ready), 64'(4'b0001));
         step();
      end
      idle();
`else
      // round-robin fairness from ptr=0
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, OP_STORE, WIDTH'(i * 16), WIDTH'(i));
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t2_grant", 64'(req_ready), 64'(1) << (c % NREQ));
         step();
      end
      idle();

      // store backpressure
      do_reset();
      lsq_store_full = 1'b1;
      set_req(0, OP_STORE, 32'h40, 32'h4);
      set_req(1, OP_LOAD, 32'h44, 32'h0);
      #1;
      chk("t3_load_first", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid[1] = 1'b0;
      #1;
      chk("t3_store_stall", 64'(req_ready), 64'(0));
      step();
      lsq_store_full = 1'b0;
      #1;
      chk("t3_store_resume", 64'(req_ready), 64'(4'b0001));
      step();
      idle();
`endif

      // response routing in issue order
      do_reset();
      set_req(2, OP_LOAD, 32'h200, 32'h0);
      step();
      idle();
      set_req(1, OP_LOAD, 32'h300, 32'h0);
      step();
      idle();
      lsq_load_valid = 1'b1;
      lsq_data_out   = 32'h12345678;
      step();
      chk("t4_rsp1_valid", 64'(rsp_valid), 64'(4'b0100));
      chk("t4_rsp1_data", 64'(rsp_data), 64'(32'h12345678));
      lsq_data_out = 32'hCAFEF00D;
      step();
      chk("t4_rsp2_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("t4_rsp2_data", 64'(rsp_data), 64'(32'hCAFEF00D));
      idle();
      step();
      chk("t4_rsp_idle", 64'(rsp_valid), 64'(0));

      // tag FIFO full
      do_reset();
      set_req(0, OP_LOAD, 32'h500, 32'h0);
      repeat (MAXOUT) step();
      #1;
      chk("t5_full_block", 64'(req_ready), 64'(0));
      step();
      lsq_load_valid = 1'b1;
      lsq_data_out   = 32'h55;
      #1;
      chk("t5_pop_cycle_block", 64'(req_ready), 64'(0));
      step();
      lsq_load_valid = 1'b0;
      #1;
      chk("t5_resume", 64'(req_ready), 64'(4'b0001));
      step();
      idle();

      // illegal opcode and orphan response
      do_reset();
      set_req(3, 4'h7, 32'h700, 32'h7);
      #1;
      chk("t6_bad_ready", 64'(req_ready), 64'(4'b1000));
      chk("t6_bad_fwd", 64'(lsq_req_valid), 64'(0));
      step();
      chk("t6_bad_err", 64'(err), 64'(1));
      idle();
      do_reset();
      lsq_load_valid = 1'b1;
      lsq_data_out   = 32'h99;
      step();
      chk("t6_orphan_err", 64'(err), 64'(1));
      chk("t6_orphan_rsp", 64'(rsp_valid), 64'(0));
      idle();

      // randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < NREQ; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            req_valid[i] = ($urandom_range(0, 2) != 0);
            req_opcode[i*4 +: 4] = (sel < 5) ? OP_LOAD : (sel < 9) ? OP_STORE : 4'($urandom_range(2, 15));
            req_addr[i*WIDTH +: WIDTH] = $urandom;
            req_data[i*WIDTH +: WIDTH] = $urandom;
         end
         lsq_store_full = ($urandom_range(0, 3) == 0);
         lsq_load_full  = ($urandom_range(0, 5) == 0);
         lsq_load_valid = ($urandom_range(0, 2) == 0);
         lsq_data_out   = $urandom;
         step();
      end
      rst = 1'b0;
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
